// File: rtl/mant_add_sched_if.sv
// mant_add_sched_if: requester, shared-adder and response signals of mant_add_sched.
interface mant_add_sched_if #(parameter int WIDTH = 24);
  logic req0_valid, req0_ready, req0_cin;
  logic req1_valid, req1_ready, req1_cin;
  logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [WIDTH-1:0] add_a, add_b, add_sum;
  logic add_cin, add_cout;
  logic rsp_valid, rsp_ready, rsp_id, rsp_cout, busy;
  logic [WIDTH-1:0] rsp_sum;
  modport master (
    output req0_valid, req0_a, req0_b, req0_cin,
    output req1_valid, req1_a, req1_b, req1_cin,
    input  req0_ready, req1_ready,
    input  add_a, add_b, add_cin,
    output add_sum, add_cout,
    input  rsp_valid, rsp_id, rsp_sum, rsp_cout, busy,
    output rsp_ready
  );
  modport slave (
    input  req0_valid, req0_a, req0_b, req0_cin,
    input  req1_valid, req1_a, req1_b, req1_cin,
    output req0_ready, req1_ready,
    output add_a, add_b, add_cin,
    input  add_sum, add_cout,
    output rsp_valid, rsp_id, rsp_sum, rsp_cout, busy,
    input  rsp_ready
  );
endinterface

// File: rtl/mant_add_sched.sv
// mant_add_sched: round-robin scheduler of two requesters onto one shared multi-cycle mantissa adder.
// Define MANT_ADD_ISO_EN to hold the adder operands at zero outside WAIT (operand isolation).
module mant_add_sched #(
  parameter int WIDTH   = 24,
  parameter int ADD_LAT = 2
) (
  input logic clk,
  input logic rst_n,
  mant_add_sched_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, state_nx;
  logic [3:0] cnt;
  logic ptr, grant, accept, done, id, cout, op_cin;
  logic [WIDTH-1:0] op_a, op_b, sum;
  // On contention the requester not served last wins; ptr resets to 1 so req0 wins first.
  assign grant = bus.req1_valid & (~bus.req0_valid | ~ptr);
  always_comb begin
    accept   = state == IDLE && (bus.req0_valid || bus.req1_valid);
    done     = state == WAIT && cnt == '0;
    state_nx = accept ? WAIT :
               done ? RESP :
               (state == RESP && bus.rsp_ready) ? IDLE : state;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      ptr    <= 1'b1;
      id     <= 1'b0;
      op_a   <= '0;
      op_b   <= '0;
      op_cin <= 1'b0;
      sum    <= '0;
      cout   <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        cnt    <= 4'(ADD_LAT - 1);
        ptr    <= grant;
        id     <= grant;
        op_a   <= grant ? bus.req1_a : bus.req0_a;
        op_b   <= grant ? bus.req1_b : bus.req0_b;
        op_cin <= grant ? bus.req1_cin : bus.req0_cin;
      end else if (cnt != '0)
        cnt <= cnt - 1'b1;
      if (done) begin
        sum  <= bus.add_sum;
        cout <= bus.add_cout;
      end
    end
  assign bus.req0_ready = rst_n & accept & ~grant;
  assign bus.req1_ready = rst_n & accept & grant;
  assign bus.rsp_valid  = state == RESP;
  assign bus.rsp_id     = id;
  assign bus.rsp_sum    = sum;
  assign bus.rsp_cout   = cout;
  assign bus.busy       = state != IDLE;
`ifdef MANT_ADD_ISO_EN
  assign bus.add_a   = state == WAIT ? op_a : '0;
  assign bus.add_b   = state == WAIT ? op_b : '0;
  assign bus.add_cin = state == WAIT & op_cin;
`else
  assign bus.add_a   = op_a;
  assign bus.add_b   = op_b;
  assign bus.add_cin = op_cin;
`endif
endmodule

// File: tb/tb_mant_add_sched.sv
// tb_mant_add_sched: directed and random stimulus against a transaction-level model of the scheduler.
module tb_mant_add_sched;
  localparam int W = 24, LAT = 2;
  logic clk = 1'b0, rst_n = 1'b0;
  mant_add_sched_if #(.WIDTH(W)) bus ();
  mant_add_sched #(.WIDTH(W), .ADD_LAT(LAT)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  // Behavioural shared adder.
  assign {bus.add_cout, bus.add_sum} = {1'b0, bus.add_a} + {1'b0, bus.add_b} + (W + 1)'(bus.add_cin);

  int vectors = 0, errors = 0, n = 0, acc = 0;
  logic act = 1'b0, m_last = 1'b1, m_id = 1'b0, m_c = 1'b0, took0 = 1'b0, took1 = 1'b0;
  logic [W-1:0] m_a = '0, m_b = '0;
  logic [W:0] m_res = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (edge %0d)", tag, got, exp, n);
    end
  endtask

  function automatic logic win1();
    return bus.req1_valid && (!bus.req0_valid || !m_last);
  endfunction

  task automatic check_outputs();
    logic rv;
    logic [W-1:0] ea, eb;
    logic ec;
    rv = act && n >= acc + LAT;
    chk("busy", bus.busy, act);
    chk("rsp_valid", bus.rsp_valid, rv);
    chk("req0_ready", bus.req0_ready, rst_n && !act && bus.req0_valid && !win1());
    chk("req1_ready", bus.req1_ready, rst_n && !act && win1());
    if (rv) begin
      chk("rsp_id", bus.rsp_id, m_id);
      chk("rsp_sum", bus.rsp_sum, m_res[W-1:0]);
      chk("rsp_cout", bus.rsp_cout, m_res[W]);
    end
`ifdef MANT_ADD_ISO_EN
    {ea, eb, ec} = (act && !rv) ? {m_a, m_b, m_c} : '0;
`else
    {ea, eb, ec} = {m_a, m_b, m_c};
`endif
    chk("add_a", bus.add_a, ea);
    chk("add_b", bus.add_b, eb);
    chk("add_cin", bus.add_cin, ec);
  endtask

  task automatic tick();
    logic w;
    #1 check_outputs();
    w = win1();
    took0 = 1'b0;
    took1 = 1'b0;
    if (rst_n && !act && (bus.req0_valid || bus.req1_valid)) begin
      act = 1'b1;
      acc = n + 1;
      m_id = w;
      m_last = w;
      m_a = w ? bus.req1_a : bus.req0_a;
      m_b = w ? bus.req1_b : bus.req0_b;
      m_c = w ? bus.req1_cin : bus.req0_cin;
      m_res = {1'b0, m_a} + {1'b0, m_b} + (W + 1)'(m_c);
      took0 = !w;
      took1 = w;
    end else if (rst_n && act && n >= acc + LAT && bus.rsp_ready)
      act = 1'b0;
    @(posedge clk);
    n++;
    @(negedge clk);
  endtask

  task automatic drain();
    int k = 0;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    while (act && k < 20) begin
      tick();
      k++;
    end
    chk("drain_timeout", act, 1'b0);
  endtask

  task automatic set_req(input int r, input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    if (r == 0) begin
      bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b; bus.req0_cin = c;
    end else begin
      bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b; bus.req1_cin = c;
    end
  endtask

  task automatic drive_rand();
    if (took0 || !bus.req0_valid) begin
      bus.req0_valid = 1'($urandom_range(0, 1));
      bus.req0_a = W'($urandom); bus.req0_b = W'($urandom); bus.req0_cin = 1'($urandom);
    end else if ($urandom_range(0, 3) == 0)
      bus.req0_a = W'($urandom);
    if (took1 || !bus.req1_valid) begin
      bus.req1_valid = 1'($urandom_range(0, 1));
      bus.req1_a = W'($urandom); bus.req1_b = W'($urandom); bus.req1_cin = 1'($urandom);
    end else if ($urandom_range(0, 3) == 0)
      bus.req1_b = W'($urandom);
    bus.rsp_ready = $urandom_range(0, 2) != 0;
  endtask

  task automatic model_reset();
    act = 1'b0; m_last = 1'b1; m_a = '0; m_b = '0; m_c = 1'b0; took0 = 1'b0; took1 = 1'b0;
  endtask

  initial begin
    bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_cin = 1'b0;
    bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_cin = 1'b0;
    bus.rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1 check_outputs();
    rst_n = 1'b1;
    // Contention right after reset: grants must go 0, 1, 0.
    set_req(0, W'($urandom), W'($urandom), 1'b0);
    set_req(1, W'($urandom), W'($urandom), 1'b1);
    bus.rsp_ready = 1'b1;
    for (int g = 0; g < 3; g++) begin
      int k = 0;
      #1;
      while (!(bus.req0_ready || bus.req1_ready) && k < 20) begin
        tick();
        k++;
        #1;
      end
      chk("r021_timeout", k < 20, 1'b1);
      chk("r021_grant", bus.req1_ready, 64'(g % 2));
      tick();
      if (took0) bus.req0_a = W'($urandom);
      if (took1) bus.req1_a = W'($urandom);
    end
    drain();
    // Single request and its latency.
    set_req(0, 24'h7FFFFF, 24'h000001, 1'b0);
    tick();
    bus.req0_valid = 1'b0;
    tick();
    #1 chk("r020_early", bus.rsp_valid, 1'b0);
    tick();
    #1 chk("r020_valid", bus.rsp_valid, 1'b1);
    chk("r020_sum", bus.rsp_sum, 24'h800000);
    chk("r020_cout", bus.rsp_cout, 1'b0);
    chk("r020_id", bus.rsp_id, 1'b0);
    drain();
    // Backpressure with both requesters waiting.
    bus.rsp_ready = 1'b0;
    set_req(1, W'($urandom), W'($urandom), 1'b1);
    tick();
    bus.req1_valid = 1'b0;
    repeat (LAT) tick();
    set_req(0, W'($urandom), W'($urandom), 1'b0);
    set_req(1, W'($urandom), W'($urandom), 1'b1);
    repeat (5) begin
      #1 chk("r022_ready", bus.req0_ready | bus.req1_ready, 1'b0);
      tick();
    end
    bus.rsp_ready = 1'b1;
    tick();
    #1 chk("r022_idle", bus.busy, 1'b0);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    drain();
    // Overflow.
    set_req(0, 24'hFFFFFF, 24'hFFFFFF, 1'b1);
    tick();
    bus.req0_valid = 1'b0;
    repeat (LAT) tick();
    #1 chk("r023_sum", bus.rsp_sum, 24'hFFFFFF);
    chk("r023_cout", bus.rsp_cout, 1'b1);
    drain();
    // Reset while in WAIT.
    set_req(0, W'($urandom), W'($urandom), 1'b1);
    set_req(1, W'($urandom), W'($urandom), 1'b1);
    tick();
    tick();
    rst_n = 1'b0;
    #1 model_reset();
    chk("r024_busy", bus.busy, 1'b0);
    chk("r024_rsp_valid", bus.rsp_valid, 1'b0);
    repeat (2) tick();
    rst_n = 1'b1;
    #1 chk("r024_prio", bus.req0_ready, 1'b1);
    tick();
    drain();
    // Random traffic.
    repeat (800) begin
      drive_rand();
      tick();
    end
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/mant_add_sched.md
MANT_ADD_SCHED -- requirements
Module: mant_add_sched

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- WIDTH, 24, mantissa operand/sum width.
- ADD_LAT, 2, cycles allowed for the shared hybrid CLA/RCA adder to settle; legal 1..15.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk  in  1  single clock, all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_a, req0_b  in  WIDTH  requester 0 operands.
- req0_cin  in  1  requester 0 carry-in.
- req1_valid, req1_ready, req1_a, req1_b, req1_cin: as requester 0, for requester 1.
- add_a, add_b  out  WIDTH  operands to the external shared adder.
- add_cin  out  1  carry-in to the shared adder.
- add_sum  in  WIDTH  sum from the shared adder.
- add_cout  in  1  carry-out from the shared adder.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts result.
- rsp_id  out  1  requester that owns the result.
- rsp_sum  out  WIDTH  captured sum.
- rsp_cout  out  1  captured carry-out.
- busy  out  1  high whenever state is not IDLE.
REQ-003 Clock SHALL be clk; reset SHALL be rst_n, asynchronous assert, active-low.

Function
REQ-004 FSM SHALL have exactly three states: IDLE, WAIT, RESP.
REQ-005 IDLE: if any reqN_valid, grant one requester; only the granted reqN_ready SHALL be high (combinational); on that edge, latch a/b/cin into operand registers, record grant id, load counter with ADD_LAT-1, go to WAIT.
REQ-006 Arbitration SHALL be round-robin: one valid wins outright; both valid wins for the requester not granted last.
REQ-007 After reset, the last-grant pointer SHALL be 1, so requester 0 wins the first contention.
REQ-008 Both reqN_ready SHALL be 0 in WAIT and RESP; a valid held through these states SHALL NOT be accepted until IDLE.
REQ-009 Operands SHALL be sampled only at the handshake edge; changes while valid and not ready SHALL have no effect.
REQ-010 WAIT: counter SHALL decrement each cycle; in the cycle counter==0, add_sum/add_cout SHALL be captured into rsp_sum/rsp_cout and state SHALL go to RESP.
REQ-011 Latency: rsp_valid SHALL rise exactly ADD_LAT rising edges after the accepting edge.
REQ-012 RESP: rsp_valid=1, rsp_id/rsp_sum/rsp_cout stable until rsp_ready=1; on that edge, go to IDLE.
REQ-013 Minimum issue period SHALL be ADD_LAT+2 cycles; there SHALL be no overlap of transactions.
REQ-014 busy SHALL equal (state != IDLE).
REQ-015 Arithmetic SHALL be performed only by the external adder; the block SHALL NOT modify sum or carry bits.

Reset
REQ-016 On rst_n low, asynchronously: state=IDLE, counter=0, pointer=1, operand registers=0, rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_cout=0, busy=0, both reqN_ready=0 while reset is asserted.
REQ-017 Reset asserted mid-WAIT or mid-RESP SHALL discard the transaction; no response SHALL be produced for it.

Configuration
REQ-018 Macro MANT_ADD_ISO_EN: when defined, add_a, add_b and add_cin SHALL be forced to 0 in IDLE and RESP (operand isolation) and driven from operand registers only in WAIT.
REQ-019 When MANT_ADD_ISO_EN is undefined, add_a, add_b and add_cin SHALL always equal the operand registers.

Verification
REQ-020 Single request, ADD_LAT=2: req0 a=0x7FFFFF, b=0x000001, cin=0 accepted at edge E0 -> rsp_valid high after E2, rsp_sum=0x800000, rsp_cout=0, rsp_id=0.
REQ-021 Contention after reset: req0 and req1 valid together -> req0 granted first; after rsp handshake, req1 (still valid) granted next; then req0 again if both remain valid.
REQ-022 Backpressure: rsp_ready held 0 for 5 cycles -> rsp_valid/sum/cout/id stable and both reqN_ready stay 0; on rsp_ready=1, IDLE next cycle.
REQ-023 Overflow: a=b=0xFFFFFF, cin=1 -> rsp_sum=0xFFFFFF, rsp_cout=1.
REQ-024 Reset in WAIT: drop rst_n one cycle after acceptance -> all outputs 0 immediately; no rsp_valid after release; next request re-arbitrated with req0 priority.
REQ-025 With MANT_ADD_ISO_EN defined: add_a/add_b/add_cin=0 in IDLE and RESP, equal to the latched operands in WAIT; undefined: always equal to the latched operands.
